// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, NOP constant and IF/ID entry type for the fetch stage
package fetch_pkg;
   localparam int FETCH_XLEN = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   typedef enum logic [1:0] {F_BOOT, F_FETCH, F_DROP, F_FAULT} fetch_state_t;
   typedef struct packed {
      logic                  valid;
      logic [31:0]           instr;
      logic [FETCH_XLEN-1:0] pc;
   } if_id_t;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: imem req/ack bus plus the IF/ID register and its stall back-pressure
interface instr_fetch_if #(parameter int XLEN = 32) ();
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic [31:0]     imem_rdata;
   logic            stall;
   logic            if_valid;
   logic [31:0]     if_instr;
   logic [XLEN-1:0] if_pc;
   modport master (output imem_req, imem_addr, if_valid, if_instr, if_pc,
                   input imem_ack, imem_rdata, stall);
   modport slave (input imem_req, imem_addr, if_valid, if_instr, if_pc,
                  output imem_ack, imem_rdata, stall);
endinterface

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry holding register for a word fetched while decode was stalled
module fetch_skid_buf import fetch_pkg::*; #(parameter type T = if_id_t) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic unload,
   input  logic clear,
   input  T     din,
   output logic full,
   output T     dout
);
   always_ff @(posedge clk) begin
      full <= !(rst || clear) && (load || (full && !unload));
      if (load) dout <= din;
   end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC owner, imem req/ack fetcher with skid buffer and redirect handling.
// FETCH_MISALIGN_CHECK_EN adds if_misalign and the F_FAULT state for misaligned PCs.
module instr_fetch import fetch_pkg::*; #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] pc_next,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
   output logic            if_misalign,
`endif
   instr_fetch_if.master   bus
);
   fetch_state_t state;
   logic [XLEN-1:0] drop_addr;
   if_id_t word, skid_q;
   logic skid_full, take, misal, fault;
`ifdef FETCH_MISALIGN_CHECK_EN
   assign misal = pc[1:0] != 2'b00;
`else
   assign misal = 1'b0;
`endif
   // F_DROP keeps presenting the abandoned address until memory answers it
   assign bus.imem_req = (state == F_FETCH && !skid_full && !misal) || state == F_DROP;
   assign bus.imem_addr = state == F_DROP ? drop_addr : {pc[XLEN-1:2], 2'b00};
   assign take = bus.imem_req && bus.imem_ack && state == F_FETCH;
   assign fault = state == F_FETCH && misal && !bus.stall;
   assign word = '{valid: 1'b1, instr: bus.imem_rdata, pc: pc};
   fetch_skid_buf #(.T(if_id_t)) u_skid (
      .clk(clk),
      .rst(rst),
      .load(take && bus.stall && !redirect),
      .unload(!bus.stall),
      .clear(redirect),
      .din(word),
      .full(skid_full),
      .dout(skid_q)
   );
   always_ff @(posedge clk)
      if (rst) begin
         state <= F_BOOT;
         pc <= RESET_PC;
         drop_addr <= '0;
         bus.if_valid <= 1'b0;
         bus.if_instr <= NOP_INSTR;
         bus.if_pc <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
         if_misalign <= 1'b0;
`endif
      end else if (redirect) begin
         state <= bus.imem_req && !bus.imem_ack ? F_DROP : F_FETCH;
         pc <= redirect_pc;
         drop_addr <= bus.imem_addr;
         bus.if_valid <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
         if_misalign <= 1'b0;
`endif
      end else begin
         state <= state == F_BOOT || (state == F_DROP && bus.imem_ack) ? F_FETCH :
                  fault ? F_FAULT : state;
         if (take) pc <= pc_next;
         if (!bus.stall) begin
            bus.if_valid <= skid_full ? skid_q.valid : take || fault;
            if (skid_full) begin
               bus.if_instr <= skid_q.instr;
               bus.if_pc <= skid_q.pc;
            end else if (take) begin
               bus.if_instr <= bus.imem_rdata;
               bus.if_pc <= pc;
            end else if (fault) begin
               bus.if_instr <= NOP_INSTR;
               bus.if_pc <= pc;
`ifdef FETCH_MISALIGN_CHECK_EN
               if_misalign <= 1'b1;
`endif
            end
         end
      end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch; memory returns rdata=addr after a programmable latency
module tb_instr_fetch;
   import fetch_pkg::*;
   typedef struct {logic [31:0] instr; logic [31:0] pc;} exp_t;
   logic clk = 1'b0, rst = 1'b1, redirect = 1'b0, force_ack = 1'b0;
   logic [31:0] pc, pc_next, redirect_pc = '0;
   int lat = 1, wait_cnt = 0, n_checks = 0, n_fail = 0;
   exp_t exp_q[$];
   exp_t mon_e;
   logic prev_pend = 1'b0, prev_rst = 1'b1;
   logic [31:0] prev_addr = '0;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic if_misalign;
`endif
   instr_fetch_if #(.XLEN(32)) bus ();
   instr_fetch #(.XLEN(32), .RESET_PC(32'h0)) dut (
      .clk(clk),
      .rst(rst),
      .pc(pc),
      .pc_next(pc_next),
      .redirect(redirect),
      .redirect_pc(redirect_pc),
`ifdef FETCH_MISALIGN_CHECK_EN
      .if_misalign(if_misalign),
`endif
      .bus(bus)
   );
   always #5 clk = ~clk;
   assign pc_next = pc + 32'd4;
   assign bus.imem_ack = force_ack || (bus.imem_req && wait_cnt == lat - 1);
   assign bus.imem_rdata = bus.imem_addr;
   always @(posedge clk) wait_cnt <= bus.imem_req && !bus.imem_ack ? wait_cnt + 1 : 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic push(input logic [31:0] a);
      exp_q.push_back('{instr: a, pc: a});
   endtask
   task automatic drain();
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
      check("drain_left", exp_q.size(), 0);
   endtask
   task automatic wait_valid();
      for (int i = 0; i < 50 && !bus.if_valid; i++) tick();
      check("wait_valid", {31'd0, bus.if_valid}, 1);
   endtask

   always @(negedge clk)
      if (!rst && bus.if_valid && !bus.stall) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: got pc %h instr %h, required no word", bus.if_pc, bus.if_instr);
         end else begin
            mon_e = exp_q.pop_front();
            check("if_pc", bus.if_pc, mon_e.pc);
            check("if_instr", bus.if_instr, mon_e.instr);
         end
      end

   always @(negedge clk) begin
      if (prev_pend && !prev_rst && !rst) begin
         check("req_hold", {31'd0, bus.imem_req}, 1);
         check("addr_hold", bus.imem_addr, prev_addr);
      end
      prev_pend <= bus.imem_req && !bus.imem_ack;
      prev_addr <= bus.imem_addr;
      prev_rst <= rst;
   end

   initial begin
      repeat (20000) @(posedge clk);
      $display("FAIL watchdog: cycle budget exhausted");
      $fatal(1);
   end

   initial begin
      bus.stall = 1'b0;
      push(0); push(4); push(8);
      tick(); tick();
      check("rst_req", {31'd0, bus.imem_req}, 0);
      check("rst_valid", {31'd0, bus.if_valid}, 0);
      check("rst_instr", bus.if_instr, NOP_INSTR);
      check("rst_if_pc", bus.if_pc, 0);
      check("rst_pc", pc, 0);
      rst = 1'b0;
      tick();
      check("boot_done_req", {31'd0, bus.imem_req}, 1);
      check("boot_done_addr", bus.imem_addr, 0);
      check("first_latency", {31'd0, bus.if_valid}, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stream_valid", {31'd0, bus.if_valid}, 1);
         check("stream_pc", bus.if_pc, 32'(i * 4));
      end
      drain();
      bus.stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("stall_req", {31'd0, bus.imem_req}, 0);
         check("stall_valid", {31'd0, bus.if_valid}, 1);
         check("stall_pc", bus.if_pc, 12);
      end
      push(12); push(16); push(20); push(24);
      bus.stall = 1'b0;
      tick();
      check("skid_pc", bus.if_pc, 16);
      check("resume_req", {31'd0, bus.imem_req}, 1);
      check("resume_addr", bus.imem_addr, 20);
      drain();
      check("pre_redir_ack", {31'd0, bus.imem_ack}, 1);
      bus.stall = 1'b1;
      redirect = 1'b1;
      redirect_pc = 32'h300;
      tick();
      redirect = 1'b0;
      check("flush_valid", {31'd0, bus.if_valid}, 0);
      check("flush_addr", bus.imem_addr, 32'h300);
      push(32'h300); push(32'h304);
      tick();
      check("flush_hold_valid", {31'd0, bus.if_valid}, 0);
      check("flush_skid_req", {31'd0, bus.imem_req}, 0);
      bus.stall = 1'b0;
      drain();
      bus.stall = 1'b1;

      rst = 1'b1;
      tick(); tick();
      lat = 3;
      bus.stall = 1'b0;
      push(0); push(4); push(8);
      rst = 1'b0;
      wait_valid();
      for (int i = 0; i < 6; i++) begin
         check("lat_valid", {31'd0, bus.if_valid}, i % 3 == 0 ? 1 : 0);
         check("lat_pc", pc, i < 3 ? 4 : 8);
         tick();
      end
      drain();
      bus.stall = 1'b1;

      rst = 1'b1;
      tick(); tick();
      lat = 2;
      bus.stall = 1'b0;
      rst = 1'b0;
      tick();
      check("drop_pre_req", {31'd0, bus.imem_req}, 1);
      check("drop_pre_ack", {31'd0, bus.imem_ack}, 0);
      redirect = 1'b1;
      redirect_pc = 32'h100;
      tick();
      redirect = 1'b0;
      check("drop_old_addr", bus.imem_addr, 0);
      check("drop_req", {31'd0, bus.imem_req}, 1);
      check("drop_valid", {31'd0, bus.if_valid}, 0);
      tick();
      check("drop_new_addr", bus.imem_addr, 32'h100);
      check("drop_valid2", {31'd0, bus.if_valid}, 0);
      push(32'h100); push(32'h104);
      tick();
      check("drop_valid3", {31'd0, bus.if_valid}, 0);
      tick();
      check("redir_valid", {31'd0, bus.if_valid}, 1);
      check("redir_pc", bus.if_pc, 32'h100);
      drain();
      bus.stall = 1'b1;

      rst = 1'b1;
      tick(); tick();
      lat = 3;
      bus.stall = 1'b0;
      rst = 1'b0;
      redirect = 1'b1;
      redirect_pc = 32'h400;
      tick();
      redirect = 1'b0;
      wait_valid();
      bus.stall = 1'b1;
      check("mid_if_pc", bus.if_pc, 32'h400);
      tick();
      check("mid_req", {31'd0, bus.imem_req}, 1);
      check("mid_ack", {31'd0, bus.imem_ack}, 0);
      rst = 1'b1;
      tick();
      check("mid_rst_req", {31'd0, bus.imem_req}, 0);
      check("mid_rst_valid", {31'd0, bus.if_valid}, 0);
      check("mid_rst_instr", bus.if_instr, NOP_INSTR);
      check("mid_rst_if_pc", bus.if_pc, 0);
      check("mid_rst_pc", pc, 0);
      rst = 1'b0;
      force_ack = 1'b1;
      tick();
      force_ack = 1'b0;
      check("late_ack_valid", {31'd0, bus.if_valid}, 0);
      check("late_ack_pc", pc, 0);
      check("late_ack_req", {31'd0, bus.imem_req}, 1);
      check("late_ack_addr", bus.imem_addr, 0);

`ifdef FETCH_MISALIGN_CHECK_EN
      rst = 1'b1;
      tick(); tick();
      lat = 1;
      bus.stall = 1'b0;
      exp_q.push_back('{instr: NOP_INSTR, pc: 32'h102});
      rst = 1'b0;
      redirect = 1'b1;
      redirect_pc = 32'h102;
      tick();
      redirect = 1'b0;
      check("mis_req", {31'd0, bus.imem_req}, 0);
      tick();
      check("mis_flag", {31'd0, if_misalign}, 1);
      check("mis_valid", {31'd0, bus.if_valid}, 1);
      check("mis_instr", bus.if_instr, NOP_INSTR);
      check("mis_pc", bus.if_pc, 32'h102);
      tick();
      check("fault_req", {31'd0, bus.imem_req}, 0);
      check("fault_pc", pc, 32'h102);
      push(32'h200); push(32'h204);
      redirect = 1'b1;
      redirect_pc = 32'h200;
      tick();
      redirect = 1'b0;
      check("fault_exit_addr", bus.imem_addr, 32'h200);
      check("fault_exit_flag", {31'd0, if_misalign}, 0);
      drain();
      bus.stall = 1'b1;
`endif
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
